ale_stream_div: RTL



---
 rtl/ale_stream_div.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ale_stream_div.sv
// rtl/ale_stream_div.sv - atmospheric light estimator with iterative reciprocal divider
//
// Purpose: takes one WIN x WIN RGB window per valid cycle, reduces it to
// per-channel minima and a dark-channel value, tracks the brightest dark pixel
// over a frame of IMG_W*IMG_H pixels, and at frame end snapshots/clamps A and
// computes floor(2^INV_W / A) per channel with a restoring radix-2 divider.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid                 window valid (no backpressure)
//   in_sof                   first pixel of a frame (qualified by in_valid)
//   in_win                   WIN*WIN pixels, pixel k at [k*3*DW +: 3*DW], R in MSBs
//   a_r, a_g, a_b            atmospheric light, held until the next result
//   inv_a_r, inv_a_g, inv_a_b  saturated Q0.INV_W reciprocals of A
//   a_valid                  one-cycle pulse when A/inv update
//   busy                     divider running
//   overrun                  one-cycle pulse when a frame end is dropped
module ale_stream_div #(
    parameter int DW       = 8,
    parameter int WIN      = 3,
    parameter int IMG_W    = 512,
    parameter int IMG_H    = 512,
    parameter int INV_W    = 16,
    parameter int A_MIN    = 16,
    parameter int TIE_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [WIN*WIN*3*DW-1:0]   in_win,
    output logic [DW-1:0]             a_r,
    output logic [DW-1:0]             a_g,
    output logic [DW-1:0]             a_b,
    output logic [INV_W-1:0]          inv_a_r,
    output logic [INV_W-1:0]          inv_a_g,
    output logic [INV_W-1:0]          inv_a_b,
    output logic                      a_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int NPIX = WIN * WIN;
    localparam int NTOT = IMG_W * IMG_H;
    localparam int CW   = (NTOT > 1) ? $clog2(NTOT) : 1;
    localparam int SW   = $clog2(INV_W + 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(NTOT - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(INV_W);
    localparam logic [DW-1:0] AMIN_C    = DW'(A_MIN);
    localparam longint RST_Q = (longint'(1) << INV_W) / ((longint'(1) << DW) - 1);
    localparam logic [INV_W-1:0] RST_INV =
        (RST_Q > ((longint'(1) << INV_W) - 1)) ? {INV_W{1'b1}} : INV_W'(RST_Q);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
    state_t state, state_nx;

    // Stage 1: window minima and pixel position
    logic [DW-1:0]   win_r, win_g, win_b;
    logic [3*DW-1:0] px;

    always_comb begin
        win_r = '1;
        win_g = '1;
        win_b = '1;
        px    = '0;
        for (int k = 0; k < NPIX; k++) begin
            px = in_win[k*3*DW +: 3*DW];
            if (px[3*DW-1 -: DW] < win_r) win_r = px[3*DW-1 -: DW];
            if (px[2*DW-1 -: DW] < win_g) win_g = px[2*DW-1 -: DW];
            if (px[DW-1:0]       < win_b) win_b = px[DW-1:0];
        end
    end

    logic [CW-1:0] pix_cnt, pix_idx;
    logic          pix_last;
    logic          s1_valid, s1_first, s1_last;
    logic [DW-1:0] s1_r, s1_g, s1_b;

    // in_sof forces index 0, discarding any partial frame in progress
    assign pix_idx  = in_sof ? '0 : pix_cnt;
    assign pix_last = (pix_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                pix_cnt  <= pix_last ? '0 : pix_idx + CW'(1);
                s1_first <= (pix_idx == '0);
                s1_last  <= pix_last;
                s1_r     <= win_r;
                s1_g     <= win_g;
                s1_b     <= win_b;
            end
        end
    end

    // Stage 2: dark channel and running maximum
    logic [DW-1:0] dark, mx_dark, mx_r, mx_g, mx_b;
    logic          upd, s2_last;

    always_comb begin
        dark = s1_r;
        if (s1_g < dark) dark = s1_g;
        if (s1_b < dark) dark = s1_b;
        upd = s1_first || ((TIE_MODE != 0) ? (dark >= mx_dark) : (dark > mx_dark));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_last <= 1'b0;
            mx_dark <= '0;
            mx_r    <= '0;
            mx_g    <= '0;
            mx_b    <= '0;
        end else begin
            s2_last <= s1_valid & s1_last;
            if (s1_valid && upd) begin
                mx_dark <= dark;
                mx_r    <= s1_r;
                mx_g    <= s1_g;
                mx_b    <= s1_b;
            end
        end
    end

    // Divider control
    logic [1:0]    ch;
    logic [SW-1:0] step;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (s2_last) state_nx = S_DIV;
            S_DIV:   if (step == LAST_STEP && ch == 2'd2) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Divider datapath: dividend is a 1 followed by INV_W zeros, fed MSB first
    logic [DW-1:0]    dv_r, dv_g, dv_b, div_d;
    logic [DW:0]      rem, rem_sh, rem_nx;
    logic [INV_W:0]   q, q_nx;
    logic [INV_W-1:0] q_sat, q_r, q_g, q_b;
    logic             ge;

    always_comb begin
        div_d  = (ch == 2'd0) ? dv_r : (ch == 2'd1) ? dv_g : dv_b;
        rem_sh = {rem[DW-1:0], (step == '0)};
        ge     = (rem_sh >= {1'b0, div_d});
        rem_nx = ge ? (rem_sh - {1'b0, div_d}) : rem_sh;
        q_nx   = {q[INV_W-1:0], ge};
        // A=1 gives 2^INV_W and A=0 gives all ones; both saturate here
        q_sat  = q_nx[INV_W] ? {INV_W{1'b1}} : q_nx[INV_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_r    <= '0;
            dv_g    <= '0;
            dv_b    <= '0;
            ch      <= '0;
            step    <= '0;
            rem     <= '0;
            q       <= '0;
            q_r     <= '0;
            q_g     <= '0;
            q_b     <= '0;
            a_r     <= '1;
            a_g     <= '1;
            a_b     <= '1;
            inv_a_r <= RST_INV;
            inv_a_g <= RST_INV;
            inv_a_b <= RST_INV;
            a_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            a_valid <= 1'b0;
            overrun <= s2_last && busy;
            case (state)
                S_IDLE: begin
                    if (s2_last) begin
                        dv_r <= (mx_r < AMIN_C) ? AMIN_C : mx_r;
                        dv_g <= (mx_g < AMIN_C) ? AMIN_C : mx_g;
                        dv_b <= (mx_b < AMIN_C) ? AMIN_C : mx_b;
                        ch   <= '0;
                        step <= '0;
                        rem  <= '0;
                        q    <= '0;
                    end
                end
                S_DIV: begin
                    if (step == LAST_STEP) begin
                        step <= '0;
                        rem  <= '0;
                        q    <= '0;
                        ch   <= ch + 2'd1;
                        case (ch)
                            2'd0:    q_r <= q_sat;
                            2'd1:    q_g <= q_sat;
                            default: q_b <= q_sat;
                        endcase
                    end else begin
                        step <= step + SW'(1);
                        rem  <= rem_nx;
                        q    <= q_nx;
                    end
                end
                S_DONE: begin
                    a_r     <= dv_r;
                    a_g     <= dv_g;
                    a_b     <= dv_b;
                    inv_a_r <= q_r;
                    inv_a_g <= q_g;
                    inv_a_b <= q_b;
                    a_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
